// File: rtl/dot_accel.sv
// Q16.16 dot-product accelerator: CSR slave plus a single-outstanding
// SDRAM read master that walks weight/activation vectors.
module dot_accel (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  output logic        slave_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  input  logic        master_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, RD_W, WAIT_W, RD_A, WAIT_A, MAC, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] wbase_q, abase_q, bias_q, n_q;
  logic        relu_q;
  logic [31:0] result_q, result_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] i_q, i_d;
  logic [31:0] w_q, w_d;
  logic [31:0] a_q, a_d;
  logic        busy, wr_en, start;
  logic signed [63:0] prod;
  logic [31:0] r_sum;
  logic        unused_wdata;

  assign busy  = (state_q != IDLE);
  assign wr_en = slave_write & ~busy;
  assign start = wr_en & (slave_address == 4'd0);
  assign slave_waitrequest = busy & (slave_read | slave_write);
  assign unused_wdata = ^slave_writedata[31:1];

  assign prod  = 64'($signed(w_q)) * 64'($signed(a_q));
  assign r_sum = acc_q + bias_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbase_q <= '0;
      abase_q <= '0;
      bias_q  <= '0;
      n_q     <= '0;
      relu_q  <= 1'b0;
    end else if (wr_en) begin
      case (slave_address)
        4'd2:    wbase_q <= slave_writedata;
        4'd3:    abase_q <= slave_writedata;
        4'd4:    bias_q  <= slave_writedata;
        4'd5:    n_q     <= slave_writedata;
        4'd6:    relu_q  <= slave_writedata[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    slave_readdata = '0;
    case (slave_address)
      4'd0:    slave_readdata = result_q;
      4'd1:    slave_readdata = result_q;
      4'd2:    slave_readdata = wbase_q;
      4'd3:    slave_readdata = abase_q;
      4'd4:    slave_readdata = bias_q;
      4'd5:    slave_readdata = n_q;
      4'd6:    slave_readdata = {31'b0, relu_q};
      default: slave_readdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      w_q      <= '0;
      a_q      <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      w_q      <= w_d;
      a_q      <= a_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    acc_d          = acc_q;
    i_d            = i_q;
    w_d            = w_q;
    a_d            = a_q;
    master_read    = 1'b0;
    master_address = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          i_d     = '0;
          state_d = (n_q != '0) ? RD_W : DONE;
        end
      end
      RD_W: begin
        master_read    = 1'b1;
        master_address = wbase_q + {i_q[29:0], 2'b00};
        if (!master_waitrequest) state_d = WAIT_W;
      end
      WAIT_W: begin
        if (master_readdatavalid) begin
          w_d     = master_readdata;
          state_d = RD_A;
        end
      end
      RD_A: begin
        master_read    = 1'b1;
        master_address = abase_q + {i_q[29:0], 2'b00};
        if (!master_waitrequest) state_d = WAIT_A;
      end
      WAIT_A: begin
        if (master_readdatavalid) begin
          a_d     = master_readdata;
          state_d = MAC;
        end
      end
      MAC: begin
        // Keep the Q16.16 middle slice; overflow wraps silently
        acc_d   = acc_q + 32'(prod >>> 16);
        i_d     = i_q + 32'd1;
        state_d = (i_q + 32'd1 == n_q) ? DONE : RD_W;
      end
      DONE: begin
        result_d = (relu_q && r_sum[31]) ? '0 : r_sum;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dot_accel.sv
// Self-checking bench for dot_accel: fixed scenarios, reset abort,
// and randomized runs against an arithmetic reference model.
module tb_dot_accel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_waitrequest;

  dot_accel dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .slave_address       (slave_address),
    .slave_read          (slave_read),
    .slave_write         (slave_write),
    .slave_writedata     (slave_writedata),
    .slave_readdata      (slave_readdata),
    .slave_waitrequest   (slave_waitrequest),
    .master_address      (master_address),
    .master_read         (master_read),
    .master_readdata     (master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest  (master_waitrequest)
  );

  always #5 clk = ~clk;

  typedef logic [31:0] vec8_t [8];
  typedef struct {
    int          n;
    bit          relu;
    logic [31:0] bias;
    logic [31:0] w;
    logic [31:0] a;
    int          stall;
    logic [31:0] res;
  } vec_t;

  int vecs = 0;
  int errs = 0;

  logic [31:0] mem [int unsigned];
  logic [31:0] got_addr [$];
  int          stall_left = 0;
  int          stab_err = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rdmem(input logic [31:0] ad);
    if (mem.exists(int'(ad))) return mem[int'(ad)];
    return 32'h0;
  endfunction

  // SDRAM model: one-cycle read latency, optional stall on next read
  initial begin
    bit          pend;
    bit          stalling;
    logic [31:0] pdata;
    logic [31:0] saddr;
    pend = 0;
    stalling = 0;
    pdata = '0;
    saddr = '0;
    master_readdatavalid = 1'b0;
    master_readdata = '0;
    master_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        stalling = 0;
        master_readdatavalid = 1'b0;
        master_waitrequest = 1'b0;
        continue;
      end
      master_readdatavalid = pend;
      master_readdata = pend ? pdata : 32'hDEADBEEF;
      pend = 0;
      if (stalling && (!master_read || master_address !== saddr))
        stab_err++;
      if (master_read && stall_left > 0) begin
        saddr = master_address;
        stalling = 1;
        master_waitrequest = 1'b1;
        stall_left--;
      end else begin
        stalling = 0;
        master_waitrequest = 1'b0;
        if (master_read) begin
          pend = 1;
          pdata = rdmem(master_address);
          got_addr.push_back(master_address);
        end
      end
    end
  end

  task automatic csr_wr(input logic [3:0] ad, input logic [31:0] d);
    int c;
    c = 0;
    @(negedge clk);
    slave_address = ad;
    slave_writedata = d;
    slave_write = 1'b1;
    #1;
    while (slave_waitrequest && c < 2000) begin
      @(negedge clk);
      #1;
      c++;
    end
    @(posedge clk);
    #1 slave_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] ad, output logic [31:0] d,
                        output int cyc);
    cyc = 0;
    @(negedge clk);
    slave_address = ad;
    slave_read = 1'b1;
    #1;
    while (slave_waitrequest && cyc < 2000) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    if (cyc >= 2000) begin
      vecs++;
      errs++;
      $display("FAIL timeout: busy did not clear");
    end
    d = slave_readdata;
    @(posedge clk);
    #1 slave_read = 1'b0;
  endtask

  function automatic logic [31:0] model(input int n, input bit relu,
                                        input logic [31:0] bias,
                                        input vec8_t w, input vec8_t a);
    logic [31:0] acc;
    logic [31:0] r;
    longint      p;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      p = longint'($signed(w[k])) * longint'($signed(a[k]));
      acc = acc + 32'(p >>> 16);
    end
    r = acc + bias;
    return (relu && $signed(r) < 0) ? 32'h0 : r;
  endfunction

  task automatic run_case(input string tag, input int n, input bit relu,
                          input logic [31:0] bias, input logic [31:0] wb,
                          input logic [31:0] ab, input vec8_t w,
                          input vec8_t a, input int stall,
                          input logic [31:0] exp_res);
    logic [31:0] rd;
    int          cyc;
    int          dummy;
    int          bad;
    for (int k = 0; k < n; k++) begin
      mem[int'(wb + 32'(4 * k))] = w[k];
      mem[int'(ab + 32'(4 * k))] = a[k];
    end
    csr_wr(4'd2, wb);
    csr_wr(4'd3, ab);
    csr_wr(4'd4, bias);
    csr_wr(4'd5, 32'(n));
    csr_wr(4'd6, {31'b0, relu});
    got_addr.delete();
    stab_err = 0;
    stall_left = stall;
    csr_wr(4'd0, 32'h0);
    csr_rd(4'd0, rd, cyc);
    chk({tag, " result@0"}, rd, exp_res);
    if (stall == 0) chk({tag, " busy cycles"}, 32'(cyc), 32'(5 * n + 1));
    csr_rd(4'd1, rd, dummy);
    chk({tag, " result@1"}, rd, exp_res);
    chk({tag, " read count"}, 32'(got_addr.size()), 32'(2 * n));
    bad = 0;
    for (int k = 0; k < got_addr.size() && k < 2 * n; k++) begin
      if (got_addr[k] !== ((k % 2 == 0) ? wb : ab) + 32'(4 * (k / 2)))
        bad++;
    end
    chk({tag, " addr seq errs"}, 32'(bad), 32'h0);
    if (stall > 0) chk({tag, " stall stability errs"}, 32'(stab_err), 32'h0);
  endtask

  initial begin
    vec_t        tbl [6];
    vec8_t       w, a;
    logic [31:0] rd;
    int          cyc;
    int          c;
    int          n;
    bit          relu;
    logic [31:0] bias, wb, ab;

    tbl[0] = '{1, 1'b0, 32'h00010000, 32'h00020000, 32'h00030000, 0, 32'h00070000};
    tbl[1] = '{0, 1'b1, 32'hFFFF0000, 32'h0, 32'h0, 0, 32'h00000000};
    tbl[2] = '{0, 1'b0, 32'hFFFF0000, 32'h0, 32'h0, 0, 32'hFFFF0000};
    tbl[3] = '{3, 1'b0, 32'h0, 32'h00010000, 32'hFFFE0000, 0, 32'hFFFA0000};
    tbl[4] = '{3, 1'b1, 32'h0, 32'h00010000, 32'hFFFE0000, 0, 32'h00000000};
    tbl[5] = '{1, 1'b0, 32'h00010000, 32'h00020000, 32'h00030000, 5, 32'h00070000};

    slave_read = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset master_read", {31'b0, master_read}, 32'h0);
    chk("reset master_address", master_address, 32'h0);
    chk("reset waitrequest", {31'b0, slave_waitrequest}, 32'h0);
    slave_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    csr_rd(4'd1, rd, cyc);
    chk("reset result", rd, 32'h0);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 8; k++) begin
        w[k] = tbl[t].w;
        a[k] = tbl[t].a;
      end
      run_case($sformatf("tbl%0d", t), tbl[t].n, tbl[t].relu, tbl[t].bias,
               32'h00001000, 32'h00008000, w, a, tbl[t].stall, tbl[t].res);
    end

    // Abort a run after the second read is accepted
    for (int k = 0; k < 8; k++) begin
      w[k] = 32'h00010000;
      a[k] = 32'h00050000;
    end
    for (int k = 0; k < 2; k++) begin
      mem[int'(32'h2000 + 32'(4 * k))] = w[k];
      mem[int'(32'h3000 + 32'(4 * k))] = a[k];
    end
    csr_wr(4'd2, 32'h2000);
    csr_wr(4'd3, 32'h3000);
    csr_wr(4'd4, 32'h11);
    csr_wr(4'd5, 32'd2);
    csr_wr(4'd6, 32'd1);
    got_addr.delete();
    stall_left = 0;
    csr_wr(4'd0, 32'h0);
    c = 0;
    while (got_addr.size() < 2 && c < 200) begin
      @(negedge clk);
      #2;
      c++;
    end
    chk("abort reached 2nd read", 32'(got_addr.size()), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort master_read", {31'b0, master_read}, 32'h0);
    chk("abort master_address", master_address, 32'h0);
    slave_read = 1'b1;
    slave_address = 4'd0;
    #1;
    chk("abort waitrequest", {31'b0, slave_waitrequest}, 32'h0);
    chk("abort result", slave_readdata, 32'h0);
    slave_read = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 7; r++) begin
      csr_rd(4'(r), rd, cyc);
      chk($sformatf("post-reset csr%0d", r), rd, 32'h0);
    end
    for (int k = 0; k < 8; k++) begin
      w[k] = tbl[0].w;
      a[k] = tbl[0].a;
    end
    run_case("after reset", 1, 1'b0, 32'h00010000, 32'h00001000,
             32'h00008000, w, a, 0, 32'h00070000);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 4);
      relu = 1'($urandom_range(0, 1));
      bias = $urandom;
      wb = 32'h00010000 + 32'($urandom_range(0, 255) * 4);
      ab = 32'h00020000 + 32'($urandom_range(0, 255) * 4);
      for (int k = 0; k < 8; k++) begin
        w[k] = $urandom;
        a[k] = (t % 2 == 0) ? 32'($signed(16'($urandom))) : $urandom;
      end
      run_case($sformatf("rand%0d", t), n, relu, bias, wb, ab, w, a,
               $urandom_range(0, 2), model(n, relu, bias, w, a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
